// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART frame scheduler.
// Holds the FSM state encoding, frame constants and the checksum rule.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GUARD,
    DRAIN
  } state_t;

  localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_LEN      = 4;
  localparam int unsigned IDX_W          = 2;
  localparam int unsigned WORD_W         = 16;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned DROP_W         = 4;

  // Frame trailer: XOR of the header and both payload bytes.
  function automatic logic [BYTE_W-1:0] frame_checksum(input logic [BYTE_W-1:0] header,
                                                       input logic [WORD_W-1:0] word);
    return header ^ word[15:8] ^ word[7:0];
  endfunction

endpackage

// File: rtl/uart_frame_scheduler_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pop frees a slot for a
// same-cycle push even when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  assign data_out = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/uart_frame_scheduler.sv
// Queues status snapshots and emits each as a 4-byte frame
// (header, high, low, checksum) over a ready/start UART handshake.
module uart_frame_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  HEADER     = HEADER_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              capture,
  input  logic [WORD_W-1:0] data_in,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  output logic              queue_full,
  output logic [DROP_W-1:0] drop_count,
  output logic              idle
);

  state_t              state;
  state_t              state_next;
  logic [WORD_W-1:0]   word;
  logic [WORD_W-1:0]   word_next;
  logic [IDX_W-1:0]    index;
  logic [IDX_W-1:0]    index_next;
  logic                tx_start_next;
  logic [BYTE_W-1:0]   tx_data_next;
  logic [BYTE_W-1:0]   issue_byte;
  logic                pop;
  logic [WORD_W-1:0]   fifo_head;
  logic                fifo_empty;
  logic                fifo_full;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (capture),
    .pop      (pop),
    .data_in  (data_in),
    .data_out (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_comb begin
    case (index)
      2'd0:    issue_byte = HEADER;
      2'd1:    issue_byte = word[15:8];
      2'd2:    issue_byte = word[7:0];
      default: issue_byte = frame_checksum(HEADER, word);
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      word     <= '0;
      index    <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_next;
      word     <= word_next;
      index    <= index_next;
      tx_start <= tx_start_next;
      tx_data  <= tx_data_next;
    end
  end

  // GUARD skips the stale tx_ready sampled while the UART latches the byte.
  always_comb begin
    state_next    = state;
    word_next     = word;
    index_next    = index;
    tx_start_next = 1'b0;
    tx_data_next  = tx_data;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          word_next  = fifo_head;
          index_next = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (tx_ready) begin
          tx_start_next = 1'b1;
          tx_data_next  = issue_byte;
          state_next    = GUARD;
        end
      end
      GUARD: state_next = DRAIN;
      DRAIN: begin
        if (tx_ready) begin
          if (index == IDX_W'(FRAME_LEN - 1)) begin
            state_next = IDLE;
          end else begin
            index_next = index + IDX_W'(1);
            state_next = ISSUE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A capture is dropped only when full and no pop frees a slot this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count <= '0;
    end else if (capture && fifo_full && !pop && (drop_count != '1)) begin
      drop_count <= drop_count + DROP_W'(1);
    end
  end

  assign queue_full = fifo_full;
  assign idle       = (state == IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed + randomized bench for uart_frame_scheduler with a UART ready model
// and a byte-stream reference built from the frame format.
module tb_uart_frame_scheduler;

  localparam logic [7:0] HDR = 8'hA5;

  logic        clock = 1'b0;
  logic        reset;
  logic        capture;
  logic [15:0] data_in;
  logic        tx_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        queue_full;
  logic [3:0]  drop_count;
  logic        idle;

  int tests = 0;
  int fails = 0;
  // UART model mode: 0 never ready, 1 always ready, 2 busy 10 cycles/byte, 3 random busy.
  int mode  = 2;
  int busy  = 0;

  logic [7:0] byte_q[$];
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  uart_frame_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .capture    (capture),
    .data_in    (data_in),
    .tx_ready   (tx_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .queue_full (queue_full),
    .drop_count (drop_count),
    .idle       (idle)
  );

  assign tx_ready = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : (busy == 0);

  always @(posedge clock) begin
    if (tx_start) begin
      byte_q.push_back(tx_data);
      busy <= (mode == 3) ? int'($urandom_range(1, 8)) : 10;
    end else if (busy > 0) begin
      busy <= busy - 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input logic [15:0] w);
    exp_q.push_back(HDR);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(HDR ^ w[15:8] ^ w[7:0]);
  endtask

  task automatic cap(input logic [15:0] w);
    capture = 1'b1;
    data_in = w;
    tick();
    capture = 1'b0;
  endtask

  task automatic wait_drain(input int nbytes, input int limit, input string tag);
    int k = 0;
    while ((byte_q.size() < nbytes || !idle) && k < limit) begin
      tick();
      k++;
    end
    chk({tag, "_timeout"}, 32'(byte_q.size() >= nbytes && idle), 32'd1);
  endtask

  task automatic wait_starts(input int n, input int limit, input string tag);
    int seen = 0;
    int k = 0;
    while (seen < n && k < limit) begin
      tick();
      k++;
      if (tx_start) seen++;
    end
    chk({tag, "_starts"}, 32'(seen), 32'(n));
  endtask

  task automatic cmp_bytes(input string tag);
    chk({tag, "_count"}, 32'(byte_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < byte_q.size() && i < exp_q.size(); i++)
      chk({tag, "_byte"}, 32'(byte_q[i]), 32'(exp_q[i]));
    byte_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] w;
    int pt[$];

    // Reset values
    reset = 1'b1; capture = 1'b0; data_in = '0; mode = 2;
    tick(); tick();
    reset = 1'b0;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_full", 32'(queue_full), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);

    // Single frame with latency and byte content
    add_frame(16'h5A3C);
    cap(16'h5A3C);
    tick();
    chk("lat_n1_start", 32'(tx_start), 32'd0);
    tick();
    chk("lat_n2_start", 32'(tx_start), 32'd1);
    chk("lat_n2_data", 32'(tx_data), 32'hA5);
    wait_drain(4, 300, "single");
    chk("single_idle", 32'(idle), 32'd1);
    chk("single_hold", 32'(tx_data), 32'hC3);
    cmp_bytes("single");

    // Burst with UART stalled: one word sits in the frame register, four fill the FIFO
    mode = 0;
    for (int i = 0; i < 5; i++) begin
      w = 16'($urandom);
      add_frame(w);
      cap(w);
    end
    chk("burst_full", 32'(queue_full), 32'd1);
    chk("burst_drop", 32'(drop_count), 32'd0);

    // Push coinciding with the IDLE pop while full
    mode = 1;
    wait_starts(4, 100, "pp");
    tick(); tick();
    w = 16'($urandom);
    add_frame(w);
    cap(w);
    mode = 0;
    chk("pp_full", 32'(queue_full), 32'd1);
    chk("pp_drop", 32'(drop_count), 32'd0);
    chk("pp_idle", 32'(idle), 32'd0);

    // Overflow: drop counter saturates, queue untouched
    for (int i = 0; i < 20; i++) begin
      cap(16'($urandom));
      chk("ovf_drop", 32'(drop_count), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    chk("ovf_full", 32'(queue_full), 32'd1);
    mode = 2;
    wait_drain(24, 1500, "order");
    cmp_bytes("order");

    // Reset mid-frame abandons the frame and flushes queue and drops
    cap(16'h1234);
    cap(16'h5678);
    wait_starts(2, 100, "mid");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_tx_start", 32'(tx_start), 32'd0);
    chk("mid_idle", 32'(idle), 32'd1);
    chk("mid_drop", 32'(drop_count), 32'd0);
    byte_q.delete();
    exp_q.delete();
    w = 16'($urandom);
    add_frame(w);
    cap(w);
    wait_drain(4, 300, "fresh");
    repeat (40) tick();
    cmp_bytes("fresh");

    // Handshake stress: ready held high, three queued words
    mode = 1;
    for (int k = 0; k < 80; k++) begin
      if (k < 3) begin
        w = 16'($urandom);
        add_frame(w);
        capture = 1'b1;
        data_in = w;
      end else begin
        capture = 1'b0;
      end
      tick();
      if (tx_start) pt.push_back(k);
    end
    chk("stress_pulses", 32'(pt.size()), 32'd12);
    for (int i = 1; i < pt.size(); i++) begin
      if (i % 4 != 0) chk("stress_gap_in", 32'(pt[i] - pt[i-1]), 32'd3);
      else            chk("stress_gap_frame", 32'(pt[i] - pt[i-1] <= 4), 32'd1);
    end
    cmp_bytes("stress");

    // Randomized traffic with variable UART busy time
    mode = 3;
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      add_frame(w);
      cap(w);
      repeat ($urandom_range(30, 60)) tick();
    end
    wait_drain(32, 2000, "rand");
    cmp_bytes("rand");
    chk("rand_drop", 32'(drop_count), 32'd0);
    chk("rand_idle", 32'(idle), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
